// File: rtl/core_run_ctrl.sv
// Run/step/breakpoint controller: drives a single-domain clock enable for the core
// with a programmable divider, PC breakpoints, halt request and a retired-cycle counter.
module core_run_ctrl #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned DIV_W  = 4,
    parameter int unsigned NUM_BP = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                     clk_i,
    input  logic                     aresetn_i,
    input  logic                     run_mode_i,
    input  logic                     step_i,
    input  logic                     halt_req_i,
    input  logic [DIV_W-1:0]         div_ratio_i,
    input  logic [XLEN-1:0]          pc_in_i,
    input  logic [NUM_BP-1:0]        bp_en_i,
    input  logic [NUM_BP*XLEN-1:0]   bp_addr_i,
    input  logic                     bp_clr_i,
    input  logic                     cnt_clr_i,
    output logic                     cpu_ce_o,
    output logic [1:0]               state_o,
    output logic [NUM_BP-1:0]        bp_hit_o,
    output logic [CNT_W-1:0]         cycle_cnt_o
);

    typedef enum logic [1:0] {
        StHalt = 2'b00,
        StRun  = 2'b01,
        StStep = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic                step_meta_q, step_sync_q, step_prev_q;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                bp_skip_q, bp_skip_d;
    logic [NUM_BP-1:0]   bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;

    logic                step_pulse;
    logic                tick;
    logic                run_ok;
    logic                bp_stop;
    logic                cpu_ce;
    logic [NUM_BP-1:0]   bp_match_vec;

    assign step_pulse = step_sync_q & ~step_prev_q;
    assign tick       = (state_q == StRun) && (div_cnt_q == div_ratio_i);
    assign run_ok     = run_mode_i & ~halt_req_i;
    // The first tick after leaving HALT is allowed past a breakpoint on the current PC.
    assign bp_stop    = (|bp_match_vec) & ~bp_skip_q;

    always_comb begin
        bp_match_vec = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            bp_match_vec[i] = bp_en_i[i] && (pc_in_i == bp_addr_i[i*XLEN +: XLEN]);
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = '0;
        bp_skip_d = bp_skip_q;
        bp_hit_d  = bp_clr_i ? '0 : bp_hit_q;
        cpu_ce    = 1'b0;

        unique case (state_q)
            StHalt: begin
                if (step_pulse) begin
                    state_d  = StStep;
                    bp_hit_d = '0;
                end else if (run_ok && (bp_hit_q == '0)) begin
                    state_d   = StRun;
                    bp_skip_d = 1'b1;
                end
            end
            StStep: begin
                cpu_ce  = 1'b1;
                state_d = StHalt;
            end
            StRun: begin
                div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
                if (tick) begin
                    bp_skip_d = 1'b0;
                end
                if (!run_ok) begin
                    state_d = StHalt;
                end else if (tick && bp_stop) begin
                    state_d  = StHalt;
                    bp_hit_d = bp_hit_d | bp_match_vec;
                end else begin
                    cpu_ce = tick;
                end
            end
            default: state_d = StHalt;
        endcase

        if (state_d != StRun) begin
            div_cnt_d = '0;
        end

        cycle_cnt_d = cnt_clr_i ? '0 : cycle_cnt_q + CNT_W'(cpu_ce);
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q     <= StHalt;
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
            step_prev_q <= 1'b0;
            div_cnt_q   <= '0;
            bp_skip_q   <= 1'b0;
            bp_hit_q    <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            step_meta_q <= step_i;
            step_sync_q <= step_meta_q;
            step_prev_q <= step_sync_q;
            div_cnt_q   <= div_cnt_d;
            bp_skip_q   <= bp_skip_d;
            bp_hit_q    <= bp_hit_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cpu_ce_o    = cpu_ce;
    assign state_o     = state_q;
    assign bp_hit_o    = bp_hit_q;
    assign cycle_cnt_o = cycle_cnt_q;

endmodule
